// File: rtl/entropy_pool_pkg.sv
// Shared sizing for the entropy pool and its round-robin arbiter.
// These mirror the widths already used by the Wishbone muxes.
package entropy_pool_pkg;
    localparam int WB_WIDTH   = 32;
    localparam int DATA_WIDTH = 16;
    localparam int CORES      = 8;
    localparam int LOG_CORES  = 3;
    localparam int CNT_WIDTH  = 8;
endpackage

// File: rtl/entropy_pool_rr_arbiter.sv
// Combinational round-robin pick: scans from ptr upward, wrapping at CORES.
// ptr is expected to stay below CORES.
module rr_arbiter
    import entropy_pool_pkg::*;
#(
    parameter int N_CORES = CORES,
    parameter int PTR_W   = LOG_CORES
) (
    input  logic [N_CORES-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               grant_valid,
    output logic [PTR_W-1:0]   grant_idx
);
    int idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < N_CORES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end
endmodule

// File: rtl/entropy_pool.sv
// Galois LFSR pool mixed with Wishbone entropy; serves low pool bits to cores
// one cycle after a round-robin grant.
module entropy_pool
    import entropy_pool_pkg::*;
#(
    parameter logic [WB_WIDTH-1:0] POLY = 32'h80200003,
    parameter logic [WB_WIDTH-1:0] SEED = 32'h00000001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WB_WIDTH-1:0]   entropy_word,
    input  logic [CORES-1:0]      core_req,
    output logic [CORES-1:0]      core_ack,
    output logic [DATA_WIDTH-1:0] core_data,
    output logic [CNT_WIDTH-1:0]  absorbed
);
    logic [WB_WIDTH-1:0]  pool, step, mix, pool_next;
    logic [LOG_CORES-1:0] rr_ptr, rr_ptr_next, grant_idx;
    logic                 grant_valid;

    rr_arbiter #(.N_CORES(CORES), .PTR_W(LOG_CORES)) u_arb (
        .req         (core_req),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A zero pool would lock the LFSR, so a zero mix reloads the seed.
    always_comb begin
        step      = (pool >> 1) ^ (pool[0] ? POLY : '0);
        mix       = step ^ entropy_word;
        pool_next = (mix == '0) ? SEED : mix;
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_valid)
            rr_ptr_next = (int'(grant_idx) == CORES - 1) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pool      <= SEED;
            rr_ptr    <= '0;
            core_ack  <= '0;
            core_data <= '0;
            absorbed  <= '0;
        end else begin
            pool     <= pool_next;
            rr_ptr   <= rr_ptr_next;
            core_ack <= grant_valid ? (CORES'(1) << grant_idx) : '0;
            if (grant_valid) core_data <= pool[DATA_WIDTH-1:0];
            if (entropy_word != '0 && absorbed != '1) absorbed <= absorbed + 1'b1;
        end
    end
endmodule
